// File: rtl/dmem_stage_pkg.sv
// Shared types, funct3 encodings and sizing helpers for the rv32i data-memory stage.
package dmem_stage_pkg;

  localparam int XLEN_P    = 32;
  localparam int LANES     = XLEN_P / 8;
  localparam int DMEM_SIZE = 4096;

  typedef logic [XLEN_P-1:0] data_t;
  typedef logic [LANES-1:0]  enable_t;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  function automatic mem_size_t f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return MEM_B;
      2'b01:   return MEM_H;
      default: return MEM_W;
    endcase
  endfunction

  // Stores only have B/H/W encodings; loads additionally have BU/HU.
  function automatic logic f3_legal(input logic write, input logic [2:0] f3);
    if (write) begin
      return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    end else begin
      return (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
    end
  endfunction

  function automatic logic f3_misaligned(input mem_size_t size, input logic [1:0] lo);
    case (size)
      MEM_H:   return lo[0];
      MEM_W:   return (lo != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] align_lo(input mem_size_t size, input logic [1:0] lo);
    case (size)
      MEM_B:   return lo;
      MEM_H:   return {lo[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dmem_stage_lsu_align.sv
// Combinational lane steering: store byte enables / replicated data, load lane select and extension.
// Honours DMEM_MISALIGN_TRAP_EN (trap misaligned H/W instead of forcing natural alignment).
module lsu_align
  import dmem_stage_pkg::*;
(
  input  logic [2:0] st_funct3,
  input  logic [1:0] st_lo,
  input  data_t      st_wdata,
  output enable_t    st_be,
  output data_t      st_data,
  input  logic       ld_write,
  input  logic [2:0] ld_funct3,
  input  logic [1:0] ld_lo,
  input  data_t      ld_word,
  output data_t      ld_data,
  output logic       ld_misalign
);

  mem_size_t  st_size_s;
  logic [1:0] st_lo_s;
  logic       st_drop_s;
  enable_t    st_be_raw_s;
  mem_size_t  ld_size_s;
  logic [1:0] ld_lo_s;
  logic       ld_drop_s;
  logic [7:0] ld_byte_s;
  logic [15:0] ld_half_s;
  data_t      ld_ext_s;

  // Store side: data is replicated across lanes so only the enables depend on the offset
  always_comb begin
    st_size_s = f3_size(st_funct3);
    st_lo_s   = align_lo(st_size_s, st_lo);
`ifdef DMEM_MISALIGN_TRAP_EN
    st_drop_s = f3_misaligned(st_size_s, st_lo);
`else
    st_drop_s = 1'b0;
`endif
    case (st_size_s)
      MEM_B: begin
        st_be_raw_s = enable_t'(4'b0001 << st_lo_s);
        st_data     = {4{st_wdata[7:0]}};
      end
      MEM_H: begin
        st_be_raw_s = enable_t'(4'b0011 << st_lo_s);
        st_data     = {2{st_wdata[15:0]}};
      end
      MEM_W: begin
        st_be_raw_s = 4'b1111;
        st_data     = st_wdata;
      end
      default: begin
        st_be_raw_s = 4'b0000;
        st_data     = 32'h0000_0000;
      end
    endcase
    if (!f3_legal(1'b1, st_funct3) || st_drop_s) begin
      st_be = 4'b0000;
    end else begin
      st_be = st_be_raw_s;
    end
  end

  // Load side: pick lane from the latched offset, then sign/zero extend
  always_comb begin
    ld_size_s = f3_size(ld_funct3);
    ld_lo_s   = align_lo(ld_size_s, ld_lo);
`ifdef DMEM_MISALIGN_TRAP_EN
    ld_drop_s   = f3_legal(ld_write, ld_funct3) && f3_misaligned(ld_size_s, ld_lo);
    ld_misalign = ld_drop_s;
`else
    ld_drop_s   = 1'b0;
    ld_misalign = 1'b0;
`endif
    ld_byte_s = ld_word[8*ld_lo_s +: 8];
    if (ld_lo_s[1]) begin
      ld_half_s = ld_word[31:16];
    end else begin
      ld_half_s = ld_word[15:0];
    end
    case (ld_funct3)
      F3_LB:   ld_ext_s = {{24{ld_byte_s[7]}}, ld_byte_s};
      F3_LBU:  ld_ext_s = {24'h00_0000, ld_byte_s};
      F3_LH:   ld_ext_s = {{16{ld_half_s[15]}}, ld_half_s};
      F3_LHU:  ld_ext_s = {16'h0000, ld_half_s};
      F3_LW:   ld_ext_s = ld_word;
      default: ld_ext_s = 32'h0000_0000;
    endcase
    if (ld_write || ld_drop_s) begin
      ld_data = 32'h0000_0000;
    end else begin
      ld_data = ld_ext_s;
    end
  end

endmodule

// File: rtl/dmem_stage.sv
// rv32i data-memory stage: valid/ready request, WAIT_STATES+1 cycle response pulse, byte-lane DMEM.
// Optional misaligned-access trapping via DMEM_MISALIGN_TRAP_EN.
module dmem_stage
  import dmem_stage_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = DMEM_SIZE,
  parameter int ADDR_W      = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [XLEN-1:0]   req_wdata_i,
  output logic              resp_valid_o,
  output logic [XLEN-1:0]   resp_rdata_o,
  output logic              stall_o,
  output logic              misalign_o
);

  localparam int         IDX_W    = $clog2(DEPTH_WORDS);
  localparam int         AW       = IDX_W + 2;
  localparam logic [3:0] LAST_CNT = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);
  localparam logic       HAS_WAIT = (WAIT_STATES > 0);

  state_t           state_r, state_nxt_s;
  logic [3:0]       cnt_r, cnt_nxt_s;
  logic             accept_s, to_resp_s, wr_en_s;
  logic             lat_write_r;
  logic [2:0]       lat_funct3_r;
  logic [AW-1:0]    lat_addr_r;
  logic             act_write_s;
  logic [2:0]       act_funct3_s;
  logic [AW-1:0]    act_addr_s;
  logic [IDX_W-1:0] req_idx_s;
  data_t            rd_word_s, st_data_s, ld_data_s;
  enable_t          st_be_s;
  logic             ld_mis_s;
  logic             unused_addr_s;

  data_t mem_r [DEPTH_WORDS];

  assign unused_addr_s = ^req_addr_i[ADDR_W-1:AW];
  assign req_idx_s     = req_addr_i[AW-1:2];
  assign req_ready_o   = (state_r == ST_IDLE);
  assign stall_o       = (state_r == ST_BUSY) |
                         ((state_r == ST_IDLE) & req_valid_i & (HAS_WAIT | ~req_write_i));
  assign wr_en_s       = accept_s & req_write_i & ~rst;

  // In IDLE the access resolves against the live request (WAIT_STATES=0 answers on the accept edge)
  assign act_write_s  = (state_r == ST_IDLE) ? req_write_i          : lat_write_r;
  assign act_funct3_s = (state_r == ST_IDLE) ? req_funct3_i         : lat_funct3_r;
  assign act_addr_s   = (state_r == ST_IDLE) ? req_addr_i[AW-1:0]   : lat_addr_r;
  assign rd_word_s    = mem_r[act_addr_s[AW-1:2]];

  lsu_align u_align (
    .st_funct3   (req_funct3_i),
    .st_lo       (req_addr_i[1:0]),
    .st_wdata    (req_wdata_i),
    .st_be       (st_be_s),
    .st_data     (st_data_s),
    .ld_write    (act_write_s),
    .ld_funct3   (act_funct3_s),
    .ld_lo       (act_addr_s[1:0]),
    .ld_word     (rd_word_s),
    .ld_data     (ld_data_s),
    .ld_misalign (ld_mis_s)
  );

  // Next-state, wait counter and handshake decode
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    accept_s    = 1'b0;
    to_resp_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_nxt_s = 4'd0;
        if (req_valid_i) begin
          accept_s = 1'b1;
          if (HAS_WAIT) begin
            state_nxt_s = ST_BUSY;
          end else begin
            state_nxt_s = ST_RESP;
            to_resp_s   = 1'b1;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_r == LAST_CNT) begin
          state_nxt_s = ST_RESP;
          to_resp_s   = 1'b1;
          cnt_nxt_s   = 4'd0;
        end else begin
          cnt_nxt_s = cnt_r + 4'd1;
        end
      end
      ST_RESP: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state and wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Request fields captured at the accept edge
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_write_r  <= 1'b0;
      lat_funct3_r <= 3'd0;
      lat_addr_r   <= '0;
    end else if (accept_s) begin
      lat_write_r  <= req_write_i;
      lat_funct3_r <= req_funct3_i;
      lat_addr_r   <= req_addr_i[AW-1:0];
    end
  end

  // Byte-lane array write; storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int i = 0; i < LANES; i++) begin
        if (st_be_s[i]) begin
          mem_r[req_idx_s][8*i +: 8] <= st_data_s[8*i +: 8];
        end
      end
    end
  end

  // Response pulse; read data holds between responses
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_o <= 1'b0;
      resp_rdata_o <= 32'h0000_0000;
      misalign_o   <= 1'b0;
    end else begin
      resp_valid_o <= to_resp_s;
      misalign_o   <= to_resp_s & ld_mis_s;
      if (to_resp_s) begin
        resp_rdata_o <= ld_data_s;
      end
    end
  end

endmodule

// File: tb/tb_dmem_stage.sv
// Directed scoreboard bench for dmem_stage: one instance with WAIT_STATES=0, one with WAIT_STATES=3.
module tb_dmem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        v0, w0, v3, w3;
  logic [2:0]  f0, f3;
  logic [31:0] a0, d0, a3, d3;
  logic        ready0, rv0, st0, mis0, ready3, rv3, st3, mis3;
  logic [31:0] rd0, rd3;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    string       tag;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  dmem_stage #(.XLEN(32), .DEPTH_WORDS(4096), .ADDR_W(32), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid_i(v0), .req_ready_o(ready0), .req_write_i(w0),
    .req_funct3_i(f0), .req_addr_i(a0), .req_wdata_i(d0), .resp_valid_o(rv0),
    .resp_rdata_o(rd0), .stall_o(st0), .misalign_o(mis0)
  );

  dmem_stage #(.XLEN(32), .DEPTH_WORDS(4096), .ADDR_W(32), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid_i(v3), .req_ready_o(ready3), .req_write_i(w3),
    .req_funct3_i(f3), .req_addr_i(a3), .req_wdata_i(d3), .resp_valid_o(rv3),
    .resp_rdata_o(rd3), .stall_o(st3), .misalign_o(mis3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic w, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel == 0) begin
      v0 = v; w0 = w; f0 = f; a0 = a; d0 = d;
    end else begin
      v3 = v; w3 = w; f3 = f; a3 = a; d3 = d;
    end
  endtask

  function automatic logic [3:0] outs(input int sel);
    // {ready, resp_valid, stall, misalign}
    if (sel == 0) return {ready0, rv0, st0, mis0};
    else          return {ready3, rv3, st3, mis3};
  endfunction

  function automatic logic [31:0] rdata_of(input int sel);
    if (sel == 0) return rd0;
    else          return rd3;
  endfunction

  task automatic access(input int sel, input logic w, input logic [2:0] fn, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] er, input logic em, input string tag);
    int         ws;
    int         n;
    int         stalls;
    logic       got;
    logic [3:0] o;
    exp_t       e;
    ws     = (sel == 0) ? 0 : 3;
    n      = 0;
    stalls = 0;
    got    = 1'b0;
    sb_q.push_back('{er, em, tag});
    @(negedge clk);
    drive(sel, 1'b1, w, fn, a, d);
    #1;
    o = outs(sel);
    check($sformatf("%s/ready_idle", tag), {31'd0, o[3]}, 32'd1);
    check($sformatf("%s/stall_req", tag), {31'd0, o[1]}, {31'd0, (ws > 0) || !w});
    stalls += int'(o[1]);
    @(posedge clk);
    #1;
    drive(sel, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      n++;
      o = outs(sel);
      if (o[2]) begin
        got = 1'b1;
      end else begin
        check($sformatf("%s/ready_busy", tag), {31'd0, o[3]}, 32'd0);
        stalls += int'(o[1]);
      end
    end
    check($sformatf("%s/resp_seen", tag), {31'd0, got}, 32'd1);
    e = sb_q.pop_front();
    if (got) begin
      check($sformatf("%s/latency", tag), 32'(n), 32'(ws + 1));
      check($sformatf("%s/rdata", e.tag), rdata_of(sel), e.rdata);
      check($sformatf("%s/misalign", e.tag), {31'd0, o[0]}, {31'd0, e.mis});
      check($sformatf("%s/stall_resp", tag), {31'd0, o[1]}, 32'd0);
      check($sformatf("%s/stall_cycles", tag), 32'(stalls), ((ws > 0) || !w) ? 32'(ws + 1) : 32'd0);
      @(negedge clk);
      o = outs(sel);
      check($sformatf("%s/pulse_end", tag), {30'd0, o[2], o[3]}, 32'd1);
      check($sformatf("%s/rdata_hold", e.tag), rdata_of(sel), e.rdata);
    end
  endtask

  initial begin
    int pulses;
    logic [3:0] o;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    drive(3, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset0", {28'd0, outs(0)}, 32'h8);
    check("reset3", {28'd0, outs(3)}, 32'h8);
    check("reset0_rdata", rd0, 32'h0);
    check("reset3_rdata", rd3, 32'h0);

    // WAIT_STATES=0 instance
    access(0, 1'b1, 3'd2, 32'h10,   32'hDEAD_BEEF, 32'h0,         1'b0, "sw_10");
    access(0, 1'b0, 3'd2, 32'h10,   32'h0,         32'hDEAD_BEEF, 1'b0, "lw_10");
    access(0, 1'b1, 3'd0, 32'h13,   32'h0000_0080, 32'h0,         1'b0, "sb_13");
    access(0, 1'b0, 3'd0, 32'h13,   32'h0,         32'hFFFF_FF80, 1'b0, "lb_13");
    access(0, 1'b0, 3'd4, 32'h13,   32'h0,         32'h0000_0080, 1'b0, "lbu_13");
    access(0, 1'b0, 3'd2, 32'h10,   32'h0,         32'h80AD_BEEF, 1'b0, "lw_10b");
    access(0, 1'b0, 3'd1, 32'h12,   32'h0,         32'hFFFF_80AD, 1'b0, "lh_12");
    access(0, 1'b0, 3'd5, 32'h10,   32'h0,         32'h0000_BEEF, 1'b0, "lhu_10");
    access(0, 1'b0, 3'd3, 32'h10,   32'h0,         32'h0,         1'b0, "ld_f3_3");
    access(0, 1'b1, 3'd7, 32'h10,   32'hFFFF_FFFF, 32'h0,         1'b0, "st_f3_7");
    access(0, 1'b0, 3'd2, 32'h10,   32'h0,         32'h80AD_BEEF, 1'b0, "lw_after_ill");
    access(0, 1'b1, 3'd2, 32'h4,    32'h0,         32'h0,         1'b0, "sw_04");
    access(0, 1'b1, 3'd1, 32'h6,    32'hBEEF_CAFE, 32'h0,         1'b0, "sh_06");
    access(0, 1'b0, 3'd2, 32'h4,    32'h0,         32'hCAFE_0000, 1'b0, "lw_04");
    access(0, 1'b1, 3'd2, 32'h4000, 32'h0000_0055, 32'h0,         1'b0, "sw_wrap");
    access(0, 1'b0, 3'd2, 32'h0,    32'h0,         32'h0000_0055, 1'b0, "lw_wrap");
`ifdef DMEM_MISALIGN_TRAP_EN
    access(0, 1'b1, 3'd2, 32'h11,   32'h1122_3344, 32'h0,         1'b1, "sw_mis");
    access(0, 1'b0, 3'd2, 32'h10,   32'h0,         32'h80AD_BEEF, 1'b0, "lw_after_mis");
    access(0, 1'b0, 3'd1, 32'h13,   32'h0,         32'h0,         1'b1, "lh_mis");
`else
    access(0, 1'b1, 3'd2, 32'h11,   32'h1122_3344, 32'h0,         1'b0, "sw_mis");
    access(0, 1'b0, 3'd2, 32'h10,   32'h0,         32'h1122_3344, 1'b0, "lw_after_mis");
    access(0, 1'b0, 3'd1, 32'h13,   32'h0,         32'h0000_1122, 1'b0, "lh_mis");
`endif

    // WAIT_STATES=3 instance
    access(3, 1'b1, 3'd2, 32'h10,   32'h80AD_BEEF, 32'h0,         1'b0, "ws3_sw_10");
    access(3, 1'b0, 3'd1, 32'h12,   32'h0,         32'hFFFF_80AD, 1'b0, "ws3_lh_12");
    access(3, 1'b0, 3'd4, 32'h11,   32'h0,         32'h0000_00BE, 1'b0, "ws3_lbu_11");

    // Reset while a load is in BUSY: response must be dropped
    @(negedge clk);
    drive(3, 1'b1, 1'b0, 3'd2, 32'h10, 32'h0);
    @(posedge clk);
    #1 drive(3, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    @(negedge clk);
    check("rst_mid/busy", {28'd0, outs(3)}, 32'h2);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid/idle", {28'd0, outs(3)}, 32'h8);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      o = outs(3);
      pulses += int'(o[2]);
    end
    check("rst_mid/no_resp", 32'(pulses), 32'd0);
    access(3, 1'b0, 3'd2, 32'h10,   32'h0,         32'h80AD_BEEF, 1'b0, "ws3_lw_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
